uart_cmd_decoder: RTL and testbench

- Upstream stage of the UART hex coder on the host-to-bus path.
- Parses ASCII command characters from the UART receiver into 34-bit command words: {type[1:0], payload[31:0]}.
- Passes each word to the wishbone command side with a one-cycle strobe, honouring downstream busy.
- Uses the same 34-bit word format and type encoding that the coder consumes.

---
 rtl/uart_cmd_decoder.sv | 145 ++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Turns a stream of ASCII command characters into {type, payload} words for the bus side.
// Words are issued the cycle after their terminator whenever downstream is free, otherwise held in EMIT.
module uart_cmd_decoder #(
   parameter int DATA_W     = 32,
   parameter int MAX_DIGITS = DATA_W / 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_stb,
   input  logic [7:0]        i_char,
   input  logic              i_busy,
   output logic              o_stb,
   output logic [DATA_W+1:0] o_word,
   output logic              o_err,
   output logic [3:0]        o_digits
);

   typedef enum logic [1:0] {IDLE, HEX, EMIT} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

   state_t              state;
   logic [1:0]          typ;
   logic [DATA_W-1:0]   acc;
   logic [3:0]          cnt;
   logic                pend;
   logic [DATA_W+1:0]   hold_word;
   logic [3:0]          hold_digits;

   logic                is_hex;
   logic                is_term;
   logic                is_cmd;
   logic                digit_in_hex;
   logic [3:0]          nib;
   logic [1:0]          cmd_type;
   logic [7:0]          up;
   logic [DATA_W+1:0]   word_now;

   always_comb begin
      is_hex   = 1'b0;
      nib      = 4'd0;
      is_cmd   = 1'b0;
      cmd_type = 2'b00;
      up       = i_char & 8'hDF;
      if (i_char >= 8'h30 && i_char <= 8'h39) begin
         is_hex = 1'b1;
         nib    = i_char[3:0];
      end else if ((i_char >= 8'h61 && i_char <= 8'h66) || (i_char >= 8'h41 && i_char <= 8'h46)) begin
         is_hex = 1'b1;
         nib    = i_char[3:0] + 4'd9;
      end
      case (up)
         8'h52:   begin is_cmd = 1'b1; cmd_type = 2'b00; end
         8'h57:   begin is_cmd = 1'b1; cmd_type = 2'b01; end
         8'h41:   begin is_cmd = 1'b1; cmd_type = 2'b10; end
         8'h53:   begin is_cmd = 1'b1; cmd_type = 2'b11; end
         default: ;
      endcase
      is_term = (i_char == 8'h0D) || (i_char == 8'h0A) || (i_char == 8'h20);
      // 'A' is both a hex digit and the set-address command: uppercase starts a new
      // command while a payload is open, lowercase is taken as a digit.
      digit_in_hex = is_hex && (i_char != 8'h41);
      word_now = {typ, (typ == 2'b11) ? {DATA_W{1'b0}} : acc};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         typ         <= 2'b00;
         acc         <= '0;
         cnt         <= 4'd0;
         pend        <= 1'b0;
         hold_word   <= '0;
         hold_digits <= 4'd0;
         o_stb       <= 1'b0;
         o_word      <= '0;
         o_err       <= 1'b0;
         o_digits    <= 4'd0;
      end else begin
         o_stb <= 1'b0;
         o_err <= 1'b0;
         case (state)
            IDLE: begin
               if (i_stb) begin
                  if (is_cmd) begin
                     typ   <= cmd_type;
                     acc   <= '0;
                     cnt   <= 4'd0;
                     state <= HEX;
                  end else if (!is_term) begin
                     o_err <= 1'b1;
                  end
               end
            end
            HEX: begin
               if (i_stb) begin
                  if (digit_in_hex) begin
                     if (cnt < MAX_CNT) begin
                        acc <= {acc[DATA_W-5:0], nib};
                        cnt <= cnt + 4'd1;
                     end else begin
                        o_err <= 1'b1;
                        state <= IDLE;
                     end
                  end else if (is_term || is_cmd) begin
                     // Issue straight away when free so the word appears the cycle after its terminator.
                     if (!i_busy) begin
                        o_stb    <= 1'b1;
                        o_word   <= word_now;
                        o_digits <= cnt;
                        state    <= is_cmd ? HEX : IDLE;
                     end else begin
                        hold_word   <= word_now;
                        hold_digits <= cnt;
                        pend        <= is_cmd;
                        state       <= EMIT;
                     end
                     if (is_cmd) begin
                        typ <= cmd_type;
                        acc <= '0;
                        cnt <= 4'd0;
                     end
                  end else begin
                     o_err <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            EMIT: begin
               if (i_stb)
                  o_err <= 1'b1;
               if (!i_busy) begin
                  o_stb    <= 1'b1;
                  o_word   <= hold_word;
                  o_digits <= hold_digits;
                  state    <= pend ? HEX : IDLE;
                  pend     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed command strings plus random character streams,
// compared every cycle against a character-level reference model.
module tb_uart_cmd_decoder;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_stb = 1'b0;
   logic [7:0]  i_char = 8'h00;
   logic        i_busy = 1'b0;
   logic        o_stb;
   logic [33:0] o_word;
   logic        o_err;
   logic [3:0]  o_digits;

   int errors = 0;
   int checks = 0;

   uart_cmd_decoder #(.DATA_W(32), .MAX_DIGITS(8)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_char(i_char), .i_busy(i_busy),
      .o_stb(o_stb), .o_word(o_word), .o_err(o_err), .o_digits(o_digits)
   );

   always #5 i_clk = ~i_clk;

   // reference model state
   bit      m_parsing, m_waiting;
   int      m_type, m_n;
   longint  m_val;
   longint  m_wait_word;
   int      m_wait_n;
   bit      exp_stb, exp_err;
   longint  exp_word;
   int      exp_dig;

   // observation counters for directed scenarios
   int          n_stb, n_err;
   logic [33:0] last_word;
   logic [3:0]  last_dig;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic int letter_type(input logic [7:0] ch);
      logic [7:0] u;
      u = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'd32 : ch;
      case (u)
         "R": return 0;
         "W": return 1;
         "A": return 2;
         "S": return 3;
         default: return -1;
      endcase
   endfunction

   function automatic int hex_val(input logic [7:0] ch);
      if (ch >= "0" && ch <= "9") return int'(ch) - 48;
      if (ch >= "a" && ch <= "f") return int'(ch) - 87;
      if (ch >= "A" && ch <= "F") return int'(ch) - 55;
      return -1;
   endfunction

   function automatic bit is_term(input logic [7:0] ch);
      return ch == 8'h0D || ch == 8'h0A || ch == 8'h20;
   endfunction

   task automatic model_reset();
      m_parsing = 0; m_waiting = 0; m_type = 0; m_n = 0; m_val = 0;
      exp_stb = 0; exp_err = 0; exp_word = 0; exp_dig = 0;
   endtask

   task automatic model_emit(input longint w, input int n);
      exp_stb = 1; exp_word = w; exp_dig = n;
   endtask

   task automatic model_step(input bit stb, input logic [7:0] ch, input bit busy);
      int     lt, hv;
      longint w;
      exp_stb = 0; exp_err = 0;
      lt = letter_type(ch);
      hv = hex_val(ch);
      if (m_waiting) begin
         if (stb) exp_err = 1;
         if (!busy) begin
            model_emit(m_wait_word, m_wait_n);
            m_waiting = 0;
         end
      end else if (stb) begin
         if (!m_parsing) begin
            if (lt >= 0) begin
               m_parsing = 1; m_type = lt; m_val = 0; m_n = 0;
            end else if (!is_term(ch)) exp_err = 1;
         end else if (hv >= 0 && ch != "A") begin
            if (m_n < 8) begin
               m_val = m_val * 16 + hv; m_n++;
            end else begin
               exp_err = 1; m_parsing = 0;
            end
         end else if (is_term(ch) || lt >= 0) begin
            w = (longint'(m_type) << 32) + ((m_type == 3) ? 0 : m_val);
            if (!busy) model_emit(w, m_n);
            else begin
               m_waiting = 1; m_wait_word = w; m_wait_n = m_n;
            end
            m_parsing = (lt >= 0);
            if (lt >= 0) begin
               m_type = lt; m_val = 0; m_n = 0;
            end
         end else begin
            exp_err = 1; m_parsing = 0;
         end
      end
   endtask

   task automatic compare_outputs();
      check_val("stb", 64'(o_stb), 64'(exp_stb));
      check_val("err", 64'(o_err), 64'(exp_err));
      check_val("word", 64'(o_word), 64'(exp_word));
      check_val("digits", 64'(o_digits), 64'(exp_dig));
      if (o_stb === 1'b1) begin
         n_stb++; last_word = o_word; last_dig = o_digits;
      end
      if (o_err === 1'b1) n_err++;
   endtask

   task automatic tick(input bit stb, input logic [7:0] ch, input bit busy);
      i_stb = stb; i_char = ch; i_busy = busy;
      @(posedge i_clk);
      model_step(stb, ch, busy);
      #1;
      compare_outputs();
   endtask

   task automatic do_reset(input bit with_char);
      i_reset = 1; i_stb = with_char; i_char = "W"; i_busy = 0;
      @(posedge i_clk);
      model_reset();
      #1;
      compare_outputs();
      i_reset = 0; i_stb = 0;
   endtask

   task automatic send(input string s, input bit busy);
      logic [7:0] c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         tick(1, c, busy);
      end
      tick(0, 8'h00, busy);
   endtask

   task automatic clear_counts();
      n_stb = 0; n_err = 0; last_word = '0; last_dig = '0;
   endtask

   initial begin
      string      pool;
      logic [7:0] c;
      model_reset();
      clear_counts();
      do_reset(0);
      do_reset(1);

      // full 8-digit write
      clear_counts();
      send("W1234abcd\n", 0);
      check_val("tp1_count", 64'(n_stb), 64'd1);
      check_val("tp1_word", 64'(last_word), 64'h1_1234ABCD);
      check_val("tp1_digits", 64'(last_dig), 64'd8);

      // lowercase command then zero-digit read
      clear_counts();
      send("a5\r", 0);
      check_val("tp2_word_a", 64'(last_word), 64'h2_00000005);
      check_val("tp2_dig_a", 64'(last_dig), 64'd1);
      send("R\n", 0);
      check_val("tp2_word_r", 64'(last_word), 64'h0_00000000);
      check_val("tp2_dig_r", 64'(last_dig), 64'd0);

      // back-to-back commands
      clear_counts();
      send("W12", 0);
      send("A34\n", 0);
      check_val("tp3_count", 64'(n_stb), 64'd2);
      check_val("tp3_word", 64'(last_word), 64'h2_00000034);
      check_val("tp3_err", 64'(n_err), 64'd0);

      // overflow on ninth digit, then status
      clear_counts();
      send("W123456789\n", 0);
      check_val("tp4_err", 64'(n_err), 64'd1);
      check_val("tp4_stb", 64'(n_stb), 64'd0);
      send("S\n", 0);
      check_val("tp4_word", 64'(last_word), 64'h3_00000000);

      // downstream busy with a dropped character
      clear_counts();
      send("WFF", 0);
      tick(1, 8'h0A, 1);
      tick(0, 8'h00, 1);
      tick(1, "x", 1);
      tick(0, 8'h00, 1);
      tick(0, 8'h00, 1);
      check_val("tp5_held", 64'(n_stb), 64'd0);
      tick(0, 8'h00, 0);
      check_val("tp5_stb", 64'(o_stb), 64'd1);
      check_val("tp5_word", 64'(last_word), 64'h1_000000FF);
      check_val("tp5_err", 64'(n_err), 64'd1);

      // reset mid-command
      clear_counts();
      send("W12", 0);
      do_reset(0);
      tick(1, 8'h0A, 0);
      tick(0, 8'h00, 0);
      check_val("tp6_stb", 64'(n_stb), 64'd0);
      check_val("tp6_word0", 64'(o_word), 64'd0);
      send("W7\n", 0);
      check_val("tp6_word", 64'(last_word), 64'h1_00000007);

      // random character streams with random busy and occasional reset
      pool = "RWASrwas0123456789abcdefABCDEF\r\n xZ!";
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 299) == 0) do_reset($urandom_range(0, 1) == 1);
         else begin
            c = pool[$urandom_range(0, pool.len() - 1)];
            tick($urandom_range(0, 2) != 0, c, $urandom_range(0, 3) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
